// File: rtl/udma_sdio_cmd_seq.sv
// udma_sdio_cmd_seq: command sequencer in front of the SDIO transceiver.
// Descriptors are queued in a small FIFO and issued one at a time: a one-cycle start pulse,
// a wait for end-of-transfer, then a status check. Failed attempts are reissued after a fixed
// idle gap, up to MAX_RETRY times, before a failure is reported.
//
// Optional feature macro: SDIO_SEQ_TIMEOUT_EN. When defined, an attempt that sees no eot_i for
// TIMEOUT_CYCLES cycles in WAIT fails with status 16'h8000. When undefined, WAIT only exits on
// eot_i, abort_i or rst_i.
//
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   desc_*_i, desc_ready_o descriptor push interface (valid/ready)
//   abort_i               flush queue and abandon the current command
//   cmd_*_o, data_*_o     descriptor latched at pop, with one-cycle cmd_start_o
//   eot_i, status_i       transceiver end-of-transfer and status
//   done_o, fail_o        per-command completion / final failure pulses
//   done_status_o/op_o    status and op of the last finished command
//   busy_o, queue_level_o, retry_cnt_o  observability
module udma_sdio_cmd_seq #(
  parameter int unsigned QUEUE_DEPTH    = 4,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned RETRY_GAP      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  localparam int unsigned LevelW = $clog2(QUEUE_DEPTH) + 1,
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              desc_valid_i,
  output logic              desc_ready_o,
  input  logic [5:0]        desc_op_i,
  input  logic [31:0]       desc_arg_i,
  input  logic [2:0]        desc_rsp_type_i,
  input  logic              desc_data_en_i,
  input  logic              desc_data_rwn_i,
  input  logic              desc_data_quad_i,
  input  logic [9:0]        desc_block_size_i,
  input  logic [7:0]        desc_block_num_i,
  input  logic              abort_i,
  output logic              cmd_start_o,
  output logic [5:0]        cmd_op_o,
  output logic [31:0]       cmd_arg_o,
  output logic [2:0]        cmd_rsp_type_o,
  output logic              data_en_o,
  output logic              data_rwn_o,
  output logic              data_quad_o,
  output logic [9:0]        data_block_size_o,
  output logic [7:0]        data_block_num_o,
  input  logic              eot_i,
  input  logic [15:0]       status_i,
  output logic              done_o,
  output logic              fail_o,
  output logic [15:0]       done_status_o,
  output logic [5:0]        done_op_o,
  output logic              busy_o,
  output logic [LevelW-1:0] queue_level_o,
  output logic [RetryW-1:0] retry_cnt_o
);

  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam int unsigned GapW = $clog2(RETRY_GAP + 1);

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] arg;
    logic [2:0]  rsp_type;
    logic        data_en;
    logic        data_rwn;
    logic        data_quad;
    logic [9:0]  block_size;
    logic [7:0]  block_num;
  } desc_t;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StGap} state_e;

  desc_t             mem_q [QUEUE_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0] level_q;

  state_e            state_q;
  desc_t             cur_q;
  logic              start_q, done_q, fail_q;
  logic [15:0]       done_status_q;
  logic [5:0]        done_op_q;
  logic [RetryW-1:0] retry_q;
  logic [GapW-1:0]   gap_q;
`ifdef SDIO_SEQ_TIMEOUT_EN
  logic [15:0]       tmo_q;
`endif

  desc_t       desc_in;
  logic        empty, full, can_pop, pop, push;
  logic        att_end;
  logic [15:0] att_status;

  always_comb begin
    desc_in = '{op: desc_op_i, arg: desc_arg_i, rsp_type: desc_rsp_type_i,
                data_en: desc_data_en_i, data_rwn: desc_data_rwn_i,
                data_quad: desc_data_quad_i, block_size: desc_block_size_i,
                block_num: desc_block_num_i};
    empty   = (level_q == '0);
    full    = (level_q == LevelW'(QUEUE_DEPTH));
    // Hold off the pop during a done/fail cycle so back-to-back starts are two cycles apart.
    can_pop = (state_q == StIdle) && !empty && !done_q && !fail_q;
    pop     = can_pop && !abort_i;
    // A full queue still accepts a push in the cycle it pops.
    desc_ready_o = !full || can_pop;
    push    = desc_valid_i && desc_ready_o && !abort_i;
  end

  // End of an attempt, with the status that decides its outcome.
  always_comb begin
    att_end    = 1'b0;
    att_status = status_i;
    if (state_q == StWait) begin
      if (eot_i) begin
        att_end = 1'b1;
`ifdef SDIO_SEQ_TIMEOUT_EN
      end else if (tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
        att_end    = 1'b1;
        att_status = 16'h8000;
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= desc_in;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      cur_q         <= '0;
      start_q       <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
      done_status_q <= '0;
      done_op_q     <= '0;
      retry_q       <= '0;
      gap_q         <= '0;
`ifdef SDIO_SEQ_TIMEOUT_EN
      tmo_q         <= '0;
`endif
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      if (abort_i) begin
        state_q <= StIdle;
        retry_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (pop) begin
              cur_q   <= mem_q[rd_ptr_q];
              retry_q <= '0;
              start_q <= 1'b1;
              state_q <= StIssue;
            end
          end
          StIssue: begin
            state_q <= StWait;
`ifdef SDIO_SEQ_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end
          StWait: begin
            if (att_end) begin
              if (att_status == '0) begin
                done_q        <= 1'b1;
                done_status_q <= att_status;
                done_op_q     <= cur_q.op;
                state_q       <= StIdle;
              end else if (retry_q < RetryW'(MAX_RETRY)) begin
                retry_q <= retry_q + 1'b1;
                gap_q   <= '0;
                state_q <= StGap;
              end else begin
                fail_q        <= 1'b1;
                done_status_q <= att_status;
                done_op_q     <= cur_q.op;
                state_q       <= StIdle;
              end
            end
`ifdef SDIO_SEQ_TIMEOUT_EN
            else begin
              tmo_q <= tmo_q + 1'b1;
            end
`endif
          end
          StGap: begin
            if (gap_q == GapW'(RETRY_GAP - 1)) begin
              start_q <= 1'b1;
              state_q <= StIssue;
            end else begin
              gap_q <= gap_q + 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign cmd_start_o       = start_q;
  assign cmd_op_o          = cur_q.op;
  assign cmd_arg_o         = cur_q.arg;
  assign cmd_rsp_type_o    = cur_q.rsp_type;
  assign data_en_o         = cur_q.data_en;
  assign data_rwn_o        = cur_q.data_rwn;
  assign data_quad_o       = cur_q.data_quad;
  assign data_block_size_o = cur_q.block_size;
  assign data_block_num_o  = cur_q.block_num;
  assign done_o            = done_q;
  assign fail_o            = fail_q;
  assign done_status_o     = done_status_q;
  assign done_op_o         = done_op_q;
  assign busy_o            = (state_q != StIdle) || !empty;
  assign queue_level_o     = level_q;
  assign retry_cnt_o       = retry_q;

endmodule

// File: tb/tb_udma_sdio_cmd_seq.sv
// Self-checking bench for udma_sdio_cmd_seq. Expected descriptors are queued on push and
// compared at each first-attempt start; expected outcomes are queued per command and
// compared at each done/fail pulse. A small responder answers starts with eot_i.
module tb_udma_sdio_cmd_seq;

  localparam int unsigned QD = 4;
  localparam int unsigned MR = 3;
  localparam int unsigned RG = 8;
  localparam int unsigned TO = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        desc_valid_i, desc_ready_o;
  logic [5:0]  desc_op_i;
  logic [31:0] desc_arg_i;
  logic [2:0]  desc_rsp_type_i;
  logic        desc_data_en_i, desc_data_rwn_i, desc_data_quad_i;
  logic [9:0]  desc_block_size_i;
  logic [7:0]  desc_block_num_i;
  logic        abort_i;
  logic        cmd_start_o;
  logic [5:0]  cmd_op_o;
  logic [31:0] cmd_arg_o;
  logic [2:0]  cmd_rsp_type_o;
  logic        data_en_o, data_rwn_o, data_quad_o;
  logic [9:0]  data_block_size_o;
  logic [7:0]  data_block_num_o;
  logic        eot_i = 1'b0;
  logic [15:0] status_i = 16'h0;
  logic        done_o, fail_o;
  logic [15:0] done_status_o;
  logic [5:0]  done_op_o;
  logic        busy_o;
  logic [2:0]  queue_level_o;
  logic [1:0]  retry_cnt_o;

  udma_sdio_cmd_seq #(
    .QUEUE_DEPTH    (QD),
    .MAX_RETRY      (MR),
    .RETRY_GAP      (RG),
    .TIMEOUT_CYCLES (TO)
  ) u_dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .desc_valid_i      (desc_valid_i),
    .desc_ready_o      (desc_ready_o),
    .desc_op_i         (desc_op_i),
    .desc_arg_i        (desc_arg_i),
    .desc_rsp_type_i   (desc_rsp_type_i),
    .desc_data_en_i    (desc_data_en_i),
    .desc_data_rwn_i   (desc_data_rwn_i),
    .desc_data_quad_i  (desc_data_quad_i),
    .desc_block_size_i (desc_block_size_i),
    .desc_block_num_i  (desc_block_num_i),
    .abort_i           (abort_i),
    .cmd_start_o       (cmd_start_o),
    .cmd_op_o          (cmd_op_o),
    .cmd_arg_o         (cmd_arg_o),
    .cmd_rsp_type_o    (cmd_rsp_type_o),
    .data_en_o         (data_en_o),
    .data_rwn_o        (data_rwn_o),
    .data_quad_o       (data_quad_o),
    .data_block_size_o (data_block_size_o),
    .data_block_num_o  (data_block_num_o),
    .eot_i             (eot_i),
    .status_i          (status_i),
    .done_o            (done_o),
    .fail_o            (fail_o),
    .done_status_o     (done_status_o),
    .done_op_o         (done_op_o),
    .busy_o            (busy_o),
    .queue_level_o     (queue_level_o),
    .retry_cnt_o       (retry_cnt_o)
  );

  typedef struct {
    logic [5:0]  op;
    logic [31:0] arg;
  } exp_desc_t;

  typedef struct {
    logic        is_fail;
    logic [15:0] status;
    logic [5:0]  op;
    logic [1:0]  retry;
  } exp_res_t;

  exp_desc_t   exp_q[$];
  exp_res_t    res_q[$];
  logic [15:0] plan_q[$];

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_start = 0;
  int          eot_cyc = 0;
  bit          eot_since = 1'b0;
  int          last_start_cyc = 0;
  int          start_gap = 0;
  int          resp_dly = 3;
  int          cd = 0;
  logic [15:0] cur_status = 16'h0;
  logic [5:0]  cur_op = 6'h0;
  bit          force_eot = 1'b0;
  logic [15:0] force_status = 16'h0;
  exp_desc_t   mon_d;
  exp_res_t    mon_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Descriptor side fields are derived from op/arg so one pair identifies a whole descriptor.
  function automatic logic [23:0] fields(input logic [5:0] op, input logic [31:0] arg);
    return {op[2:0], op[0], op[1], op[2], arg[9:0], arg[17:10]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and eot responder.
  always @(negedge clk) begin
    if (cmd_start_o === 1'b1) begin
      n_start++;
      start_gap = cyc - last_start_cyc;
      last_start_cyc = cyc;
      if (retry_cnt_o == 2'd0) begin
        if (exp_q.size() == 0) begin
          check("spurious_start", 32'd1, 32'd0);
        end else begin
          mon_d = exp_q.pop_front();
          cur_op = mon_d.op;
          check("start_op", 32'(cmd_op_o), 32'(mon_d.op));
          check("start_arg", cmd_arg_o, mon_d.arg);
          check("start_fields", 32'({cmd_rsp_type_o, data_en_o, data_rwn_o, data_quad_o,
                                     data_block_size_o, data_block_num_o}),
                32'(fields(mon_d.op, mon_d.arg)));
        end
      end else begin
        check("retry_op", 32'(cmd_op_o), 32'(cur_op));
        if (eot_since) check("retry_gap", 32'(cyc - eot_cyc), 32'(RG + 1));
      end
      eot_since = 1'b0;
    end
    if (done_o === 1'b1 || fail_o === 1'b1) begin
      check("done_fail_excl", 32'(done_o & fail_o), 32'd0);
      if (eot_since) check("done_lat", 32'(cyc - eot_cyc), 32'd1);
      if (res_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_r = res_q.pop_front();
        check("outcome_fail", 32'(fail_o), 32'(mon_r.is_fail));
        check("outcome_status", 32'(done_status_o), 32'(mon_r.status));
        check("outcome_op", 32'(done_op_o), 32'(mon_r.op));
        check("outcome_retry", 32'(retry_cnt_o), 32'(mon_r.retry));
      end
    end
    eot_i = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        eot_i    = 1'b1;
        status_i = cur_status;
      end
    end
    if (cmd_start_o === 1'b1 && plan_q.size() > 0) begin
      cur_status = plan_q.pop_front();
      cd = resp_dly;
    end
    if (force_eot) begin
      eot_i    = 1'b1;
      status_i = force_status;
    end
    if (eot_i) begin
      eot_cyc   = cyc;
      eot_since = 1'b1;
    end
  end

  task automatic push_desc(input logic [5:0] op, input logic [31:0] arg);
    int n = 0;
    @(negedge clk);
    while (!desc_ready_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      check("push_timeout", 32'd0, 32'd1);
      return;
    end
    desc_valid_i      = 1'b1;
    desc_op_i         = op;
    desc_arg_i        = arg;
    desc_rsp_type_i   = op[2:0];
    desc_data_en_i    = op[0];
    desc_data_rwn_i   = op[1];
    desc_data_quad_i  = op[2];
    desc_block_size_i = arg[9:0];
    desc_block_num_i  = arg[17:10];
    exp_q.push_back('{op, arg});
    @(posedge clk);
    #1 desc_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int  n = 0;
    bit  ok = 1'b0;
    while (n < limit && !ok) begin
      @(negedge clk);
      n++;
      if (!busy_o && res_q.size() == 0 && exp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
    #1;
  endtask

  initial begin
    int n;
    int s0;
    rst_i = 1'b1;
    desc_valid_i = 1'b0;
    desc_op_i = '0;
    desc_arg_i = '0;
    desc_rsp_type_i = '0;
    desc_data_en_i = 1'b0;
    desc_data_rwn_i = 1'b0;
    desc_data_quad_i = 1'b0;
    desc_block_size_i = '0;
    desc_block_num_i = '0;
    abort_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    // Reset state
    check("rst_ready", 32'(desc_ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_level", 32'(queue_level_o), 32'd0);
    check("rst_start", 32'(cmd_start_o), 32'd0);
    check("rst_done", 32'({done_o, fail_o}), 32'd0);
    check("rst_cmd", 32'(cmd_op_o) | cmd_arg_o, 32'd0);
    check("rst_done_info", 32'({done_status_o, done_op_o}), 32'd0);
    check("rst_retry", 32'(retry_cnt_o), 32'd0);

    // Single command, start latency
    plan_q.push_back(16'h0);
    res_q.push_back('{1'b0, 16'h0, 6'd17, 2'd0});
    push_desc(6'd17, 32'h200);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cmd_start_o !== 1'b1 && n < 10);
    check("start_lat", 32'(n), 32'd2);
    wait_idle(200);
    check("done_op_17", 32'(done_op_o), 32'd17);

    // Fill the queue behind a slow command, then push into a full queue as it pops
    resp_dly = 20;
    for (int i = 0; i < 5; i++) begin
      plan_q.push_back(16'h0);
      res_q.push_back('{1'b0, 16'h0, 6'(i + 1), 2'd0});
      push_desc(6'(i + 1), 32'h1000 * i + i);
    end
    check("full_level", 32'(queue_level_o), 32'd4);
    check("full_ready", 32'(desc_ready_o), 32'd0);
    check("full_busy", 32'(busy_o), 32'd1);
    plan_q.push_back(16'h0);
    res_q.push_back('{1'b0, 16'h0, 6'd6, 2'd0});
    push_desc(6'd6, 32'h3_5a5);
    check("full_push_pop_level", 32'(queue_level_o), 32'd4);
    wait_idle(1000);
    resp_dly = 3;

    // Every attempt fails: MR retries, then fail
    s0 = n_start;
    for (int i = 0; i <= int'(MR); i++) plan_q.push_back(16'h0004);
    res_q.push_back('{1'b1, 16'h0004, 6'h29, 2'(MR)});
    push_desc(6'h29, 32'hdead_0077);
    wait_idle(500);
    check("fail_starts", 32'(n_start - s0), 32'(MR + 1));
    check("fail_retry_hold", 32'(retry_cnt_o), 32'(MR));
    check("fail_status_hold", 32'(done_status_o), 32'h0004);

    // Fail once then succeed
    s0 = n_start;
    plan_q.push_back(16'h0010);
    plan_q.push_back(16'h0000);
    res_q.push_back('{1'b0, 16'h0, 6'h0c, 2'd1});
    push_desc(6'h0c, 32'h0001_2345);
    wait_idle(500);
    check("retry_ok_starts", 32'(n_start - s0), 32'd2);

    // Abort in WAIT with two queued, eot and a push in the same cycle
    s0 = n_start;
    push_desc(6'h21, 32'h21);
    push_desc(6'h22, 32'h22);
    push_desc(6'h23, 32'h23);
    repeat (2) @(posedge clk);
    #1;
    check("abort_pre_level", 32'(queue_level_o), 32'd2);
    @(posedge clk);
    #1;
    abort_i = 1'b1;
    force_eot = 1'b1;
    force_status = 16'h0;
    desc_valid_i = 1'b1;
    desc_op_i = 6'h3f;
    check("abort_ready", 32'(desc_ready_o), 32'd1);
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    force_eot = 1'b0;
    desc_valid_i = 1'b0;
    exp_q.delete();
    check("abort_level", 32'(queue_level_o), 32'd0);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_no_done", 32'({done_o, fail_o}), 32'd0);
    check("abort_hold_op", 32'(cmd_op_o), 32'h21);
    check("abort_retry", 32'(retry_cnt_o), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_restart", 32'(n_start - s0), 32'd1);
    check("abort_done_op_kept", 32'(done_op_o), 32'h0c);

    // Reset mid-command with a pending eot
    push_desc(6'h30, 32'h30);
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b1;
    force_eot = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    force_eot = 1'b0;
    exp_q.delete();
    check("mrst_cmd", 32'(cmd_op_o) | cmd_arg_o, 32'd0);
    check("mrst_done_info", 32'({done_status_o, done_op_o}), 32'd0);
    check("mrst_level_busy", 32'({queue_level_o, busy_o}), 32'd0);
    check("mrst_ready", 32'(desc_ready_o), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("mrst_idle", 32'(busy_o), 32'd0);

`ifdef SDIO_SEQ_TIMEOUT_EN
    // No eot at all: every attempt times out
    s0 = n_start;
    res_q.push_back('{1'b1, 16'h8000, 6'd9, 2'(MR)});
    push_desc(6'd9, 32'h99);
    wait_idle(2000);
    check("tmo_starts", 32'(n_start - s0), 32'(MR + 1));
    check("tmo_start_gap", 32'(start_gap), 32'(1 + TO + RG));
`endif

    check("final_level", 32'(queue_level_o), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
